// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer that turns LFSR (address, data) values into valid/ready write beats.
// Optional abort input is enabled by defining LFSR_BURST_ABORT_EN.
module lfsr_burst_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
`ifdef LFSR_BURST_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              lfsr_en_addr,
    output logic              lfsr_en_data,
    input  logic [ADDR_W-1:0] lfsr_addr,
    input  logic [DATA_W-1:0] lfsr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [LEN_W-1:0]  beats_sent
);

    typedef enum logic [2:0] {IDLE, CAPT, VALID, STEP, DONE} state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   len_q, len_n, beats_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [DATA_W-1:0]  data_n;
    logic               abort_i;

`ifdef LFSR_BURST_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    always_comb begin
        state_n = state;
        len_n   = len_q;
        beats_n = beats_sent;
        addr_n  = wr_addr;
        data_n  = wr_data;
        case (state)
            IDLE: begin
                if (start) begin
                    beats_n = '0;
                    if (burst_len != '0) begin
                        len_n   = burst_len;
                        state_n = CAPT;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            CAPT: begin
                if (abort_i) begin
                    state_n = DONE;
                end else begin
                    addr_n  = lfsr_addr;
                    data_n  = lfsr_data;
                    state_n = VALID;
                end
            end
            VALID: begin
                // abort takes priority over a same-cycle accept: the beat is dropped
                if (abort_i) begin
                    state_n = DONE;
                end else if (wr_ready) begin
                    beats_n = beats_sent + 1'b1;
                    state_n = STEP;
                end
            end
            STEP: begin
                if (abort_i || beats_sent == len_q) state_n = DONE;
                else                                state_n = CAPT;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // every output is a registered decode of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            len_q        <= '0;
            beats_sent   <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_valid     <= 1'b0;
            lfsr_en_addr <= 1'b0;
            lfsr_en_data <= 1'b0;
        end else begin
            state        <= state_n;
            len_q        <= len_n;
            beats_sent   <= beats_n;
            wr_addr      <= addr_n;
            wr_data      <= data_n;
            busy         <= (state_n != IDLE);
            done         <= (state_n == DONE);
            wr_valid     <= (state_n == VALID);
            lfsr_en_addr <= (state_n == STEP);
            lfsr_en_data <= (state_n == STEP);
        end
    end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Self-checking bench for lfsr_burst_ctrl: a local LFSR model feeds the DUT, a
// predictor queue holds the expected beat sequence, vector table plus corner sequences.
module tb_lfsr_burst_ctrl;
    localparam int DATA_W = 32, ADDR_W = 10, LEN_W = 10;
    localparam logic [ADDR_W-1:0] SEED_A = 10'h001;
    localparam logic [DATA_W-1:0] SEED_D = 32'hACE1_0001;

    logic clk = 1'b0;
    logic rst, start, wr_ready;
    logic [LEN_W-1:0]  burst_len;
    logic busy, done, lfsr_en_addr, lfsr_en_data, wr_valid;
    logic [ADDR_W-1:0] lfsr_addr, wr_addr;
    logic [DATA_W-1:0] lfsr_data, wr_data;
    logic [LEN_W-1:0]  beats_sent;
`ifdef LFSR_BURST_ABORT_EN
    logic abort;
`endif

    always #5 clk = ~clk;

    lfsr_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
`ifdef LFSR_BURST_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .lfsr_en_addr(lfsr_en_addr), .lfsr_en_data(lfsr_en_data),
        .lfsr_addr(lfsr_addr), .lfsr_data(lfsr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .beats_sent(beats_sent)
    );

    function automatic logic [ADDR_W-1:0] next_a(input logic [ADDR_W-1:0] a);
        return {a[8:0], a[9] ^ a[6]};
    endfunction
    function automatic logic [DATA_W-1:0] next_d(input logic [DATA_W-1:0] d);
        return d[0] ? ((d >> 1) ^ 32'h8020_0003) : (d >> 1);
    endfunction

    // PRN source seen by the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_addr <= SEED_A;
            lfsr_data <= SEED_D;
        end else begin
            if (lfsr_en_addr) lfsr_addr <= next_a(lfsr_addr);
            if (lfsr_en_data) lfsr_data <= next_d(lfsr_data);
        end
    end

    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } beat_t;
    typedef struct { int len; int stall; int lat; } vec_t;

    beat_t             exp_q[$];
    logic [ADDR_W-1:0] seen[$];
    logic [ADDR_W-1:0] pa, prev_addr;
    logic [DATA_W-1:0] pd, prev_data;
    logic              prev_hs, prev_valid;
    int compared = 0, mismatched = 0;
    int hs_cnt = 0, en_cnt = 0, done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beats(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{a: pa, d: pd});
            pa = next_a(pa);
            pd = next_d(pd);
        end
    endtask

    // one clock: monitor at negedge, return 1 time unit after posedge
    task automatic tick();
        beat_t e;
        logic  hs;
        @(negedge clk);
        if (!rst) begin
            chk("en_pair", lfsr_en_data, lfsr_en_addr);
            chk("en_after_accept", lfsr_en_addr, prev_hs);
            if (prev_valid && !prev_hs && wr_valid) begin
                chk("addr_stable", wr_addr, prev_addr);
                chk("data_stable", wr_data, prev_data);
            end
            if (lfsr_en_addr) en_cnt++;
            if (done) done_cnt++;
            hs = wr_valid && wr_ready;
            if (hs) begin
                hs_cnt++;
                seen.push_back(wr_addr);
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL beat_unexpected: got addr %0h expected no beat", wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_addr", wr_addr, e.a);
                    chk("beat_data", wr_data, e.d);
                end
            end
            prev_hs = hs; prev_valid = wr_valid; prev_addr = wr_addr; prev_data = wr_data;
        end else begin
            prev_hs = 1'b0; prev_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int stall, output int lat);
        int d0 = done_cnt;
        lat = 0;
        while (done_cnt == d0 && lat < 4000) begin
            wr_ready = (stall == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall);
            tick();
            lat++;
        end
        if (done_cnt == d0) begin
            compared++; mismatched++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
        end
    endtask

    task automatic start_burst(input int len);
        burst_len = len[LEN_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    vec_t vecs[6];
    int hs0, en0, d0, lat, dups;

    initial begin
        vecs[0] = '{4, 0, 13};
        vecs[1] = '{1, 0, 4};
        vecs[2] = '{0, 0, 1};
        vecs[3] = '{7, 0, 22};
        vecs[4] = '{5, 40, -1};
        vecs[5] = '{3, 70, -1};
        rst = 1'b1; start = 1'b0; wr_ready = 1'b0; burst_len = '0;
`ifdef LFSR_BURST_ABORT_EN
        abort = 1'b0;
`endif
        pa = SEED_A; pd = SEED_D; prev_hs = 1'b0; prev_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_valid", wr_valid, 0);
        chk("rst_en", {lfsr_en_addr, lfsr_en_data}, 0); chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0); chk("rst_beats", beats_sent, 0);
        rst = 1'b0;
        tick();

        // start-to-valid latency, then reset while VALID is stalled
        push_beats(5);
        wr_ready = 1'b0;
        start_burst(5);
        chk("lat_capt_valid", wr_valid, 0);
        tick();
        chk("lat_valid", wr_valid, 1);
        chk("lat_busy", busy, 1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", wr_valid, 0); chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
        chk("midrst_en", {lfsr_en_addr, lfsr_en_data}, 0); chk("midrst_beats", beats_sent, 0);
        chk("midrst_addr", wr_addr, 0);
        tick();
        rst = 1'b0;
        exp_q.delete(); seen.delete();
        pa = SEED_A; pd = SEED_D;
        tick(); tick();
        chk("midrst_no_done", done_cnt, d0);
        chk("midrst_idle", busy, 0);

        for (int i = 0; i < 6; i++) begin
            hs0 = hs_cnt; en0 = en_cnt; d0 = done_cnt;
            push_beats(vecs[i].len);
            wr_ready = (vecs[i].stall == 0);
            start_burst(vecs[i].len);
            wait_done(vecs[i].stall, lat);
            if (vecs[i].lat >= 0) chk("vec_latency", lat, vecs[i].lat);
            wr_ready = 1'b0;
            tick();
            chk("vec_beats_sent", beats_sent, vecs[i].len);
            chk("vec_accepts", hs_cnt - hs0, vecs[i].len);
            chk("vec_en_pulses", en_cnt - en0, vecs[i].len);
            chk("vec_single_done", done_cnt - d0, 1);
            chk("vec_idle", {busy, wr_valid}, 0);
            chk("vec_queue_empty", exp_q.size(), 0);
        end

        // backpressure: first beat stalled five cycles
        hs0 = hs_cnt; d0 = done_cnt;
        push_beats(2);
        wr_ready = 1'b0;
        start_burst(2);
        tick();
        en0 = en_cnt;
        repeat (5) tick();
        chk("bp_no_en", en_cnt - en0, 0);
        chk("bp_valid_held", wr_valid, 1);
        chk("bp_beats_zero", beats_sent, 0);
        wait_done(0, lat);
        wr_ready = 1'b0;
        tick();
        chk("bp_beats_sent", beats_sent, 2);
        chk("bp_accepts", hs_cnt - hs0, 2);
        chk("bp_queue_empty", exp_q.size(), 0);

        // start while busy must not re-latch length
        hs0 = hs_cnt; d0 = done_cnt;
        push_beats(3);
        wr_ready = 1'b1;
        start_burst(3);
        tick(); tick();
        burst_len = 10'd9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0, lat);
        tick(); tick();
        chk("busy_start_beats", beats_sent, 3);
        chk("busy_start_accepts", hs_cnt - hs0, 3);
        chk("busy_start_done", done_cnt - d0, 1);
        chk("busy_start_idle", busy, 0);

`ifdef LFSR_BURST_ABORT_EN
        // abort while VALID: beat dropped, no step
        hs0 = hs_cnt; en0 = en_cnt; d0 = done_cnt;
        wr_ready = 1'b0;
        start_burst(3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abv_valid_low", wr_valid, 0);
        wait_done(0, lat);
        tick();
        chk("abv_beats", beats_sent, 0);
        chk("abv_en", en_cnt - en0, 0);
        chk("abv_done", done_cnt - d0, 1);

        // abort during STEP after the second accept
        hs0 = hs_cnt; en0 = en_cnt; d0 = done_cnt;
        push_beats(2);
        wr_ready = 1'b1;
        start_burst(8);
        lat = 0;
        while (hs_cnt - hs0 < 2 && lat < 100) begin tick(); lat++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(0, lat);
        tick();
        chk("abs_beats", beats_sent, 2);
        chk("abs_en", en_cnt - en0, 2);
        chk("abs_accepts", hs_cnt - hs0, 2);
        chk("abs_done", done_cnt - d0, 1);
        chk("abs_queue_empty", exp_q.size(), 0);
`endif

        // three back-to-back bursts continue the PRN sequence
        for (int b = 0; b < 3; b++) begin
            push_beats(4);
            wr_ready = 1'b1;
            start_burst(4);
            wait_done(0, lat);
            tick();
            chk("b2b_beats", beats_sent, 4);
        end
        chk("b2b_queue_empty", exp_q.size(), 0);

        dups = 0;
        for (int i = 0; i < seen.size(); i++)
            for (int j = i + 1; j < seen.size(); j++)
                if (seen[i] == seen[j]) dups++;
        chk("addr_unique", dups, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
